// File: rtl/io_write_arbiter_pkg.sv
// Shared definitions for the output-port write channel: port map, requester
// and arbiter state encodings.
package io_write_arbiter_pkg;

  localparam logic [7:0] IO_BASE   = 8'h80;
  localparam logic [7:0] PORT0_OFS = 8'h00;
  localparam logic [7:0] PORT1_OFS = 8'h04;
  localparam logic [7:0] PORT2_OFS = 8'h08;
  localparam logic [7:0] PORT3_OFS = 8'h0C;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/io_write_arbiter_addr_check.sv
// Combinational legality decode for an IO port byte address: upper bits zero,
// inside the 16-byte port window at IO_BASE, word aligned.
module io_addr_check #(
  parameter logic [7:0] IO_BASE = 8'h80
) (
  input  logic [31:0] addr,
  output logic        legal
);

  // Bits [3:2] select the port and are don't-care for legality.
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFF3;

  assign legal = ((addr & ADDR_MASK) == {24'h0, IO_BASE[7:4], 4'h0});

endmodule

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter sharing the output-port write channel between the CPU
// store path and the debug path, with a bounded debug lock and a write stage.
module io_write_arbiter #(
  parameter logic [7:0] IO_BASE  = io_write_arbiter_pkg::IO_BASE,
  parameter int         LOCK_MAX = 16
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_data,
  input  logic        dbg_lock,
  output logic        out_we,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        err_pulse,
  output logic [31:0] err_addr,
  output logic        locked
);
  import io_write_arbiter_pkg::*;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  logic [0:0]  state_q;
  logic        last_grant_q;
  logic [7:0]  lock_cnt_q;
  logic        cpu_prio_q;
  logic        relock_blk_q;

  logic        cpu_xfer, dbg_xfer, vld_p0, legal_p0;
  logic [31:0] addr_p0, data_p0;
  logic        lock_limit, force_exit;

  logic        vld_p1, err_p1;
  logic [31:0] addr_p1, data_p1, err_addr_p1;

  // Stage p0: grant decision from control state and valids only
  always_comb begin
    cpu_ready = 1'b0;
    dbg_ready = 1'b0;
    if (state_q == ST_LOCKED) begin
      dbg_ready = dbg_valid;
    end else if (cpu_valid && (cpu_prio_q || !dbg_valid || last_grant_q == REQ_DBG)) begin
      cpu_ready = 1'b1;
    end else if (dbg_valid) begin
      dbg_ready = 1'b1;
    end
  end

  assign cpu_xfer   = cpu_valid && cpu_ready;
  assign dbg_xfer   = dbg_valid && dbg_ready;
  assign vld_p0     = cpu_xfer || dbg_xfer;
  assign addr_p0    = dbg_xfer ? dbg_addr : cpu_addr;
  assign data_p0    = dbg_xfer ? dbg_data : cpu_data;
  assign lock_limit = (lock_cnt_q == LOCK_LAST);
  // A release with dbg_lock low wins over the limit: no forced CPU priority.
  assign force_exit = (state_q == ST_LOCKED) && dbg_lock && lock_limit;

  io_addr_check #(.IO_BASE(IO_BASE)) u_addr_check (
    .addr  (addr_p0),
    .legal (legal_p0)
  );

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      last_grant_q <= REQ_DBG;
      lock_cnt_q   <= 8'd0;
      cpu_prio_q   <= 1'b0;
      relock_blk_q <= 1'b0;
    end else begin
      cpu_prio_q <= force_exit;
      if (force_exit)     relock_blk_q <= 1'b1;
      else if (!dbg_lock) relock_blk_q <= 1'b0;
      if (vld_p0) last_grant_q <= dbg_xfer ? REQ_DBG : REQ_CPU;
      if (state_q == ST_ARB) begin
        if (dbg_xfer && dbg_lock && !relock_blk_q) begin
          state_q    <= ST_LOCKED;
          lock_cnt_q <= 8'd0;
        end
      end else begin
        lock_cnt_q <= lock_cnt_q + 8'd1;
        if (!dbg_lock || lock_limit) state_q <= ST_ARB;
      end
    end
  end

  // Stage p1: registered write towards the bank, illegal requests dropped
  always_ff @(posedge io_clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      addr_p1     <= 32'd0;
      data_p1     <= 32'd0;
      err_addr_p1 <= 32'd0;
    end else begin
      vld_p1 <= vld_p0 && legal_p0;
      err_p1 <= vld_p0 && !legal_p0;
      if (vld_p0 && legal_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (vld_p0 && !legal_p0) err_addr_p1 <= addr_p0;
    end
  end

  assign out_we    = vld_p1;
  assign out_addr  = addr_p1;
  assign out_data  = data_p1;
  assign err_pulse = err_p1;
  assign err_addr  = err_addr_p1;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter: handshakes, round robin, debug lock,
// address errors and mid-operation reset with hand-computed expectations.
module tb_io_write_arbiter;

  logic        io_clk;
  logic        reset;
  logic        cpu_valid, cpu_ready;
  logic [31:0] cpu_addr, cpu_data;
  logic        dbg_valid, dbg_ready;
  logic [31:0] dbg_addr, dbg_data;
  logic        dbg_lock;
  logic        out_we;
  logic [31:0] out_addr, out_data;
  logic        err_pulse;
  logic [31:0] err_addr;
  logic        locked;

  int n_assert = 0;
  int n_fail   = 0;

  io_write_arbiter dut (
    .io_clk    (io_clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_lock  (dbg_lock),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .err_addr  (err_addr),
    .locked    (locked)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  logic [31:0] exp_data [4];
  logic [31:0] exp_addr [4];
  int ci, di;

  initial begin
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_addr = 32'h0; cpu_data = 32'h0;
    dbg_valid = 1'b0; dbg_addr = 32'h0; dbg_data = 32'h0;
    dbg_lock = 1'b0;
    tick();
    tick();
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_locked", 32'(locked), 32'd0);
    reset = 1'b0;

    // single CPU write
    cpu_valid = 1'b1; cpu_addr = 32'h84; cpu_data = 32'hDEADBEEF;
    #1;
    chk("t1_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("t1_dbg_ready", 32'(dbg_ready), 32'd0);
    tick();
    cpu_valid = 1'b0;
    chk("t1_out_we", 32'(out_we), 32'd1);
    chk("t1_out_addr", out_addr, 32'h84);
    chk("t1_out_data", out_data, 32'hDEADBEEF);
    tick();
    chk("t1_idle_we", 32'(out_we), 32'd0);
    chk("t1_hold_addr", out_addr, 32'h84);
    chk("t1_hold_data", out_data, 32'hDEADBEEF);

    // lone debug write, leaves last grant on debug
    dbg_valid = 1'b1; dbg_addr = 32'h88; dbg_data = 32'h55;
    #1;
    chk("t2_dbg_alone_ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("t2_dbg_out_data", out_data, 32'h55);

    // both valid for four cycles: CPU, DBG, CPU, DBG
    exp_data[0] = 32'h1; exp_data[1] = 32'hA; exp_data[2] = 32'h2; exp_data[3] = 32'hB;
    exp_addr[0] = 32'h80; exp_addr[1] = 32'h8C; exp_addr[2] = 32'h80; exp_addr[3] = 32'h8C;
    ci = 0; di = 0;
    cpu_valid = 1'b1; cpu_addr = 32'h80;
    dbg_valid = 1'b1; dbg_addr = 32'h8C;
    for (int i = 0; i < 4; i++) begin
      cpu_data = 32'(1 + ci);
      dbg_data = 32'(10 + di);
      #1;
      chk("rr_cpu_ready", 32'(cpu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dbg_ready", 32'(dbg_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("rr_out_we", 32'(out_we), 32'd1);
      chk("rr_out_data", out_data, exp_data[i]);
      chk("rr_out_addr", out_addr, exp_addr[i]);
      if (i % 2 == 0) ci++; else di++;
    end

    // lock raised while the CPU holds the turn
    cpu_addr = 32'h80; cpu_data = 32'h100;
    dbg_addr = 32'h84; dbg_data = 32'h200;
    dbg_lock = 1'b1;
    #1;
    chk("lk_first_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("lk_first_dbg_ready", 32'(dbg_ready), 32'd0);
    tick();
    chk("lk_grant_dbg_ready", 32'(dbg_ready), 32'd1);
    chk("lk_grant_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("lk_grant_locked", 32'(locked), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("lk_hold_locked", 32'(locked), 32'd1);
      chk("lk_hold_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("lk_hold_dbg_ready", 32'(dbg_ready), 32'd1);
      tick();
    end
    chk("lk_exit_locked", 32'(locked), 32'd0);
    chk("lk_exit_cpu_prio", 32'(cpu_ready), 32'd1);
    chk("lk_exit_dbg_ready", 32'(dbg_ready), 32'd0);
    tick();
    chk("lk_after_dbg_ready", 32'(dbg_ready), 32'd1);
    chk("lk_after_locked", 32'(locked), 32'd0);
    tick();
    chk("lk_norelock_locked", 32'(locked), 32'd0);
    chk("lk_norelock_cpu_ready", 32'(cpu_ready), 32'd1);
    tick();
    dbg_lock = 1'b0; dbg_valid = 1'b0;
    #1;
    chk("lk_drop_cpu_ready", 32'(cpu_ready), 32'd1);
    tick();
    dbg_lock = 1'b1; dbg_valid = 1'b1;
    #1;
    chk("lk_relock_dbg_ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("lk_relock_locked", 32'(locked), 32'd1);
    dbg_lock = 1'b0; cpu_valid = 1'b0; dbg_valid = 1'b0;
    tick();
    chk("lk_release_locked", 32'(locked), 32'd0);

    // illegal addresses: accepted and dropped
    cpu_valid = 1'b1; cpu_addr = 32'h90; cpu_data = 32'h1;
    #1;
    chk("err90_ready", 32'(cpu_ready), 32'd1);
    tick();
    chk("err90_we", 32'(out_we), 32'd0);
    chk("err90_pulse", 32'(err_pulse), 32'd1);
    chk("err90_addr", err_addr, 32'h90);
    cpu_addr = 32'h82;
    #1;
    chk("err82_ready", 32'(cpu_ready), 32'd1);
    tick();
    chk("err82_we", 32'(out_we), 32'd0);
    chk("err82_pulse", 32'(err_pulse), 32'd1);
    chk("err82_addr", err_addr, 32'h82);
    cpu_addr = 32'h180;
    #1;
    chk("err180_ready", 32'(cpu_ready), 32'd1);
    tick();
    chk("err180_we", 32'(out_we), 32'd0);
    chk("err180_pulse", 32'(err_pulse), 32'd1);
    chk("err180_addr", err_addr, 32'h180);
    cpu_valid = 1'b0;
    tick();
    chk("err_idle_pulse", 32'(err_pulse), 32'd0);
    chk("err_sticky_addr", err_addr, 32'h180);

    // reset while a write is in flight and the lock is held
    dbg_valid = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'h88; dbg_data = 32'h77;
    #1;
    chk("rm_dbg_ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("rm_out_we", 32'(out_we), 32'd1);
    chk("rm_out_data", out_data, 32'h77);
    chk("rm_locked", 32'(locked), 32'd1);
    reset = 1'b1; dbg_valid = 1'b0; dbg_lock = 1'b0;
    tick();
    chk("rm_rst_we", 32'(out_we), 32'd0);
    chk("rm_rst_locked", 32'(locked), 32'd0);
    chk("rm_rst_data", out_data, 32'h0);
    reset = 1'b0;
    cpu_valid = 1'b1; cpu_addr = 32'h8C; cpu_data = 32'h31;
    dbg_valid = 1'b1; dbg_addr = 32'h80; dbg_data = 32'h32;
    #1;
    chk("rm_tie_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rm_tie_dbg_ready", 32'(dbg_ready), 32'd0);
    tick();
    chk("rm_tie_out_data", out_data, 32'h31);
    chk("rm_tie_out_addr", out_addr, 32'h8C);

    // lock released in the same cycle the counter reaches its limit
    dbg_lock = 1'b1;
    #1;
    chk("rl_dbg_ready", 32'(dbg_ready), 32'd1);
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("rl_hold_locked", 32'(locked), 32'd1);
      tick();
    end
    dbg_lock = 1'b0;
    #1;
    chk("rl_last_locked", 32'(locked), 32'd1);
    chk("rl_last_dbg_ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("rl_arb_locked", 32'(locked), 32'd0);
    chk("rl_tie_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rl_tie_dbg_ready", 32'(dbg_ready), 32'd0);
    tick();
    dbg_lock = 1'b1;
    #1;
    chk("rl_next_dbg_ready", 32'(dbg_ready), 32'd1);
    tick();
    chk("rl_relock_locked", 32'(locked), 32'd1);
    cpu_valid = 1'b0; dbg_valid = 1'b0; dbg_lock = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
